// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared FSM state type and default counter width for pulse_meter.
//   CW_DEFAULT : default width of measurement counters and status registers
//   state_t    : measurement FSM states
package pulse_meter_pkg;
   localparam int CW_DEFAULT = 32;
   typedef enum logic [1:0] {DISABLED, ARM, HIGH, LOW} state_t;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registered previous-value bit with combinational rise/fall decode.
//   clk_i     : clock
//   reset_n_i : async active-low reset, clears the previous-value bit
//   d_i       : level being watched
//   rise_o    : d_i=1 while previous sample was 0
//   fall_o    : d_i=0 while previous sample was 1
module edge_detect (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);
   logic prev_q;
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) prev_q <= 1'b0;
      else prev_q <= d_i;
   end
   assign rise_o = d_i & ~prev_q;
   assign fall_o = ~d_i & prev_q;
endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures high time and rise-to-rise period of a pulse stream and counts pulses/errors.
//   clk_i, reset_n_i : clock, reset (async assert, clock-synchronised release, active-low)
//   enable_i         : measurement enable
//   inp_i            : pulse stream under measurement
//   perr_i           : error strobe, its rising edges are counted
//   WIDTH_MIN        : short-pulse threshold in clocks (0 disables short_o)
//   CLEAR_WSTB       : one-cycle clear of all statistics, restarts the measurement
//   WIDTH, PERIOD    : last high time / last rise-to-rise time in clocks
//   PULSE_CNT        : completed pulses; PERR_CNT : perr_i rises
//   OVERFLOW         : sticky, set when any counter saturates
//   valid_o, short_o : one-cycle strobes for PERIOD update and short pulse
module pulse_meter
   import pulse_meter_pkg::*;
#(
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          enable_i,
   input  logic          inp_i,
   input  logic          perr_i,
   input  logic [CW-1:0] WIDTH_MIN,
   input  logic          CLEAR_WSTB,
   output logic [CW-1:0] WIDTH,
   output logic [CW-1:0] PERIOD,
   output logic [CW-1:0] PULSE_CNT,
   output logic [CW-1:0] PERR_CNT,
   output logic          OVERFLOW,
   output logic          valid_o,
   output logic          short_o
);
   localparam logic [CW-1:0] MAX = '1;
   localparam logic [CW-1:0] ONE = 1;
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == MAX) ? v : v + ONE;
   endfunction
   logic [1:0] rst_sync_q;
   logic rst_n, in_rise, in_fall, perr_rise, perr_fall_unused;
   state_t state_q, state_d;
   logic [CW-1:0] wcnt_q, wcnt_d, pcnt_q, pcnt_d;
   logic [CW-1:0] width_q, width_d, period_q, period_d;
   logic [CW-1:0] pulse_cnt_q, pulse_cnt_d, perr_cnt_q, perr_cnt_d;
   logic overflow_q, overflow_d, valid_q, valid_d, short_q, short_d;
   // Reset asserts asynchronously but releases two clocks later, in step with clk_i.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) rst_sync_q <= '0;
      else rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];
   edge_detect u_inp_edge (
      .clk_i     (clk_i),
      .reset_n_i (rst_n),
      .d_i       (inp_i),
      .rise_o    (in_rise),
      .fall_o    (in_fall)
   );
   edge_detect u_perr_edge (
      .clk_i     (clk_i),
      .reset_n_i (rst_n),
      .d_i       (perr_i),
      .rise_o    (perr_rise),
      .fall_o    (perr_fall_unused)
   );
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      pcnt_d      = pcnt_q;
      width_d     = width_q;
      period_d    = period_q;
      pulse_cnt_d = pulse_cnt_q;
      valid_d     = 1'b0;
      short_d     = 1'b0;
      perr_cnt_d  = perr_rise ? sat_inc(perr_cnt_q) : perr_cnt_q;
      if (CLEAR_WSTB) begin
         state_d     = enable_i ? ARM : DISABLED;
         wcnt_d      = '0;
         pcnt_d      = '0;
         width_d     = '0;
         period_d    = '0;
         pulse_cnt_d = '0;
         perr_cnt_d  = '0;
      end else if (!enable_i) begin
         state_d = DISABLED;
      end else begin
         case (state_q)
            DISABLED: state_d = ARM;
            // A rise needs a prior low sample, so a level already high on entry is ignored.
            ARM: if (in_rise) begin
               state_d = HIGH;
               wcnt_d  = ONE;
               pcnt_d  = ONE;
            end
            HIGH: begin
               pcnt_d = sat_inc(pcnt_q);
               if (in_fall) begin
                  state_d     = LOW;
                  width_d     = wcnt_q;
                  pulse_cnt_d = sat_inc(pulse_cnt_q);
                  short_d     = wcnt_q < WIDTH_MIN;
               end else begin
                  wcnt_d = sat_inc(wcnt_q);
               end
            end
            LOW: if (in_rise) begin
               state_d  = HIGH;
               period_d = pcnt_q;
               valid_d  = 1'b1;
               wcnt_d   = ONE;
               pcnt_d   = ONE;
            end else begin
               pcnt_d = sat_inc(pcnt_q);
            end
            default: state_d = DISABLED;
         endcase
      end
      // Counters only sit at MAX after saturating, and clear zeroes them all.
      overflow_d = ~CLEAR_WSTB & (overflow_q | (wcnt_d == MAX) | (pcnt_d == MAX) |
                                  (pulse_cnt_d == MAX) | (perr_cnt_d == MAX));
   end
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DISABLED;
         wcnt_q      <= '0;
         pcnt_q      <= '0;
         width_q     <= '0;
         period_q    <= '0;
         pulse_cnt_q <= '0;
         perr_cnt_q  <= '0;
         overflow_q  <= 1'b0;
         valid_q     <= 1'b0;
         short_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         pcnt_q      <= pcnt_d;
         width_q     <= width_d;
         period_q    <= period_d;
         pulse_cnt_q <= pulse_cnt_d;
         perr_cnt_q  <= perr_cnt_d;
         overflow_q  <= overflow_d;
         valid_q     <= valid_d;
         short_q     <= short_d;
      end
   end
   assign WIDTH     = width_q;
   assign PERIOD    = period_q;
   assign PULSE_CNT = pulse_cnt_q;
   assign PERR_CNT  = perr_cnt_q;
   assign OVERFLOW  = overflow_q;
   assign valid_o   = valid_q;
   assign short_o   = short_q;
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: randomized and directed stimulus for pulse_meter against a timestamp-based reference model.
module tb_pulse_meter;
   localparam int CW = 8;
   localparam int MAXV = 255;
   logic clk = 1'b0, rstn = 1'b1, en = 1'b0, inp = 1'b0, perr = 1'b0, clr = 1'b0;
   logic [CW-1:0] wmin = '0;
   logic [CW-1:0] width, period, pulse_cnt, perr_cnt;
   logic overflow, valid, short_s;
   int n_cmp = 0, n_err = 0, n_valid = 0, n_short = 0;
   // Reference model: measurement phase plus timestamps of the last rise.
   int m_ph = 0, cyc = 0, rise_t = 0, hold = 0;
   int m_w = 0, m_p = 0, m_pc = 0, m_ec = 0;
   bit m_ovf = 0, m_v = 0, m_s = 0, p_inp = 0, p_perr = 0;
   logic en_r, in_r;
   always #5 clk = ~clk;
   pulse_meter #(.CW(CW)) dut (
      .clk_i      (clk),
      .reset_n_i  (rstn),
      .enable_i   (en),
      .inp_i      (inp),
      .perr_i     (perr),
      .WIDTH_MIN  (wmin),
      .CLEAR_WSTB (clr),
      .WIDTH      (width),
      .PERIOD     (period),
      .PULSE_CNT  (pulse_cnt),
      .PERR_CNT   (perr_cnt),
      .OVERFLOW   (overflow),
      .valid_o    (valid),
      .short_o    (short_s)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_ph = 0; m_w = 0; m_p = 0; m_pc = 0; m_ec = 0;
      m_ovf = 0; m_v = 0; m_s = 0; p_inp = 0; p_perr = 0;
      hold = 2;
   endtask
   task automatic model_step();
      bit r, f, er;
      int w;
      cyc++;
      if (hold > 0) begin
         hold--;
         return;
      end
      r = inp && !p_inp;
      f = !inp && p_inp;
      er = perr && !p_perr;
      p_inp = inp;
      p_perr = perr;
      m_v = 0;
      m_s = 0;
      if (clr) begin
         m_w = 0; m_p = 0; m_pc = 0; m_ec = 0; m_ovf = 0;
         m_ph = en ? 1 : 0;
         return;
      end
      if (er && m_ec < MAXV) m_ec++;
      if (!en) m_ph = 0;
      else case (m_ph)
         0: m_ph = 1;
         1: if (r) begin rise_t = cyc; m_ph = 2; end
         2: if (f) begin
            w = cyc - rise_t;
            m_w = (w > MAXV) ? MAXV : w;
            if (m_pc < MAXV) m_pc++;
            m_s = m_w < int'(wmin);
            m_ph = 3;
         end
         default: if (r) begin
            w = cyc - rise_t;
            m_p = (w > MAXV) ? MAXV : w;
            m_v = 1;
            rise_t = cyc;
            m_ph = 2;
         end
      endcase
      // Time since the rise, counted inclusively, must fit in CW bits.
      if (m_ph >= 2 && rise_t != cyc && cyc - rise_t + 1 >= MAXV) m_ovf = 1;
      if (m_pc == MAXV || m_ec == MAXV) m_ovf = 1;
   endtask
   task automatic check_all();
      chk("valid_o", valid, m_v);
      chk("short_o", short_s, m_s);
      chk("WIDTH", width, m_w);
      chk("PERIOD", period, m_p);
      chk("PULSE_CNT", pulse_cnt, m_pc);
      chk("PERR_CNT", perr_cnt, m_ec);
      chk("OVERFLOW", overflow, m_ovf);
   endtask
   task automatic step(input logic e, input logic i, input logic p, input logic c);
      en = e; inp = i; perr = p; clr = c;
      @(posedge clk);
      model_step();
      #1 check_all();
      if (valid === 1'b1) n_valid++;
      if (short_s === 1'b1) n_short++;
      @(negedge clk);
   endtask
   task automatic do_reset();
      #2 rstn = 1'b0;
      #1 model_reset();
      chk("rst_valid", valid, 0);
      chk("rst_short", short_s, 0);
      chk("rst_width", width, 0);
      chk("rst_period", period, 0);
      chk("rst_pulse", pulse_cnt, 0);
      chk("rst_perr", perr_cnt, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clk);
      rstn = 1'b1;
   endtask
   task automatic pulse_train(input int n, input int hi, input int per);
      for (int k = 0; k < n; k++)
         for (int j = 0; j < per; j++) step(1'b1, j < hi, 1'b0, 1'b0);
   endtask
   initial begin
      do_reset();
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
      // 3-high / 10-period stream
      step(1'b1, 1'b0, 1'b0, 1'b1);
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
      n_valid = 0;
      pulse_train(5, 3, 10);
      chk("t1_valids", n_valid, 4);
      chk("t1_width", width, 3);
      chk("t1_period", period, 10);
      chk("t1_pulses", pulse_cnt, 5);
      // short-pulse threshold boundary
      wmin = 8'd5; n_short = 0;
      pulse_train(3, 3, 10);
      chk("t2_short5", n_short, 3);
      wmin = 8'd3; n_short = 0;
      pulse_train(3, 3, 10);
      chk("t2_short3", n_short, 0);
      wmin = 8'd0;
      // input already high when enabled
      step(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t3_nocount", pulse_cnt, 0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_pulses", pulse_cnt, 1);
      chk("t3_width", width, 4);
      // saturation then clear
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (300) step(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t4_width", width, 255);
      chk("t4_ovf", overflow, 1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("t4_clr_width", width, 0);
      chk("t4_clr_period", period, 0);
      chk("t4_clr_pulses", pulse_cnt, 0);
      chk("t4_clr_ovf", overflow, 0);
      // clear coincident with a rise
      pulse_train(2, 3, 10);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("t5_valid", valid, 0);
      chk("t5_period", period, 0);
      repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
      pulse_train(2, 3, 10);
      chk("t5_width", width, 3);
      chk("t5_period2", period, 10);
      chk("t5_pulses", pulse_cnt, 2);
      // reset mid-HIGH, then error rises while disabled
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
      do_reset();
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("t6_perr", perr_cnt, 4);
      // randomized traffic
      en_r = 1'b1; in_r = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (k == 1500) do_reset();
         if ($urandom_range(0, 99) == 0) en_r = 1'b0;
         else if ($urandom_range(0, 9) == 0) en_r = 1'b1;
         if ($urandom_range(0, 3) == 0) in_r = ~in_r;
         if ($urandom_range(0, 199) == 0) wmin = CW'($urandom_range(0, 8));
         step(en_r, in_r, $urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
